ef_pwm32_ramp_seq: RTL and testbench
====================================

Name: ef_pwm32_ramp_seq

Overview:
Duty-cycle ramp sequencer for one compare channel of the 32-bit PWM.
- Software programs start, end, step and dwell values, then issues start. The block steps the compare value once per N PWM periods, saturating at the end value.
- Updates align to the PWM period boundary (period_end pulse from the PWM counter), so the output never glitches mid-period.
- Sits between the register file and the PWM cmpA/cmpB input; one instance per channel.

Parameters:
W, 32, width of compare values (matches PWM counter width)
HW, 16, width of the dwell (hold_periods) counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  1-cycle pulse; arms a ramp; ignored while busy
abort  in  1  1-cycle pulse; stops the sequence from any state
loop_en  in  1  0 = one-shot; 1 = triangle loop (ramp back and forth until abort)
period_end  in  1  1-cycle pulse from PWM when the counter completes a period
cmp_start  in  W  first compare value
cmp_end  in  W  final compare value
cmp_step  in  W  unsigned step magnitude
hold_periods  in  HW  extra periods each value is held (0 = change every period)
cmp_out  out  W  compare value driven to the PWM
update  out  1  1-cycle pulse in the cycle cmp_out changes
busy  out  1  high in ARM or HOLD
done  out  1  1-cycle pulse when a one-shot ramp reaches cmp_end

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, cmp_out=0, update=0, busy=0, done=0, dwell counter=0, dir=up.
- Input sampling: on an accepted start, latch cmp_start, cmp_end, cmp_step, hold_periods and loop_en into internal registers. Later input changes have no effect until the next start.
- Direction: dir=up if cmp_end >= cmp_start, else down.
- States:
  - IDLE: start -> ARM.
  - ARM: wait for period_end; then cmp_out<=start value, update=1, dwell=0, and go to HOLD.
  - Early finish from ARM: if start==end or step==0, a one-shot finishes at that same load: done=1, go to IDLE. In loop mode with start==end or step==0, go to HOLD and keep cmp_out constant until abort.
  - HOLD: on period_end with dwell<hold_periods: dwell++.
  - HOLD: on period_end with dwell==hold_periods: dwell=0 and cmp_out<=next, update=1.
- Next-value arithmetic: computed in W+1 bits.
  - up: next = min(cmp_out+step, target).
  - down: next = max(cmp_out-step, target), with no underflow below target.
- Reaching the target (next==target):
  - one-shot: done=1 in the same cycle as the update; go to IDLE.
  - loop: swap target between latched start and end and invert dir; stay in HOLD.
- Latency: cmp_out/update/done are registered and assert the cycle after period_end is sampled high.
- Abort: abort in any state -> IDLE next cycle. cmp_out holds its current value; no done, no update. abort and start in the same cycle: abort wins. abort and period_end in the same cycle: abort wins, no update.
- start in ARM/HOLD: ignored; it is not queued.
- busy: combinational decode of state (ARM or HOLD).
- Wrap-around: cmp_out never wraps; saturation arithmetic guarantees this even with cmp_step = 2^W-1.
- cmp_out value vs PWM top: cmp_out > top is legal. The PWM treats it as an unreachable compare; this block does not check it.

Decomposition:
- Package ef_pwm32_seq_pkg holds:
  - state typedef (IDLE, ARM, HOLD) with 2-bit encoding;
  - defaults for W and HW.
- Sub-module ef_pwm32_sat_step: combinational saturating add/sub, with inputs (cur, step, target, dir) and outputs (next, hit_target). It is reused by the future cmpB dead-time sequencer.
- The FSM, dwell counter and latches stay in the top module.

Test Plan:
- Up ramp, one-shot: start=2, end=8, step=3, hold=0, 4 period_end pulses -> cmp_out 2,5,8 on pulses 1-3; done with the third update; busy low after; pulse 4 gives no update.
- Saturation: start=2, end=8, step=4 -> 2,6,8 (clamped); start=10, end=1, step=4 -> 10,6,2,1; done on the value 1.
- Dwell: start=0, end=4, step=2, hold=2, 9 period_end pulses -> 0 on pulse 1, 2 on pulse 4, 4 on pulse 7 with done; update pulses exactly 3.
- Triangle loop: loop_en=1, start=1, end=3, step=1, hold=0 -> 1,2,3,2,1,2,3...; done never asserts; abort mid-ramp at cmp_out=2 -> IDLE, cmp_out stays 2, no done.
- Degenerate and race cases:
  - step=0 one-shot, start=5 -> first period_end loads 5 with done.
  - start==end=7 -> same behaviour.
  - start asserted while busy -> ignored.
  - abort and period_end in the same cycle -> no update.
- Async reset mid-HOLD (rst asserted between clk edges) -> cmp_out=0, busy=0 immediately; after release, a fresh start works normally.

Source files
------------

// File: rtl/ef_pwm32_seq_pkg.sv
// Shared types and width defaults for the PWM compare-value sequencers.
// Pure declarations: no logic, no latency, no flow control.
package ef_pwm32_seq_pkg;

    localparam int W_DEF  = 32;
    localparam int HW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ef_pwm32_sat_step.sv
// Saturating compare step toward a target. Combinational (zero latency), no backpressure.
// The result clamps at target in either direction and never wraps.
module ef_pwm32_sat_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] target,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         hit_target
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, cur} + {1'b0, step};
        // diff[W] set means the subtraction borrowed past zero
        diff = {1'b0, cur} - {1'b0, step};
        next = target;
        if (dir) begin
            if (sum < {1'b0, target})
                next = sum[W-1:0];
        end else begin
            if (!diff[W] && (diff > {1'b0, target}))
                next = diff[W-1:0];
        end
    end

    assign hit_target = (next == target);

endmodule

// File: rtl/ef_pwm32_ramp_seq.sv
// Period-aligned compare ramp sequencer for one PWM channel (one-shot or triangle loop).
// cmp_out/update/done register one cycle after period_end; start is dropped while busy.
module ef_pwm32_ramp_seq
    import ef_pwm32_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int HW = HW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          loop_en,
    input  logic          period_end,
    input  logic [W-1:0]  cmp_start,
    input  logic [W-1:0]  cmp_end,
    input  logic [W-1:0]  cmp_step,
    input  logic [HW-1:0] hold_periods,
    output logic [W-1:0]  cmp_out,
    output logic          update,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nxt;
    logic [HW-1:0] dwell;
    logic [W-1:0]  lat_start, lat_end, lat_step, target;
    logic [HW-1:0] lat_hold;
    logic          lat_loop, dir_up, degen;

    logic          load_cfg, load_first, do_step, dwell_inc, finish, flip;
    logic [W-1:0]  step_val;
    logic          step_hit;

    ef_pwm32_sat_step #(.W(W)) u_step (
        .cur        (cmp_out),
        .step       (lat_step),
        .target     (target),
        .dir        (dir_up),
        .next       (step_val),
        .hit_target (step_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_cfg   = 1'b0;
        load_first = 1'b0;
        do_step    = 1'b0;
        dwell_inc  = 1'b0;
        finish     = 1'b0;
        flip       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load_cfg  = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (period_end) begin
                    load_first = 1'b1;
                    if (degen && !lat_loop) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // A degenerate loop parks on its first value until abort
                if (abort) begin
                    state_nxt = IDLE;
                end else if (period_end && !degen) begin
                    if (dwell < lat_hold) begin
                        dwell_inc = 1'b1;
                    end else begin
                        do_step = 1'b1;
                        if (step_hit) begin
                            if (lat_loop) begin
                                flip = 1'b1;
                            end else begin
                                finish    = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_out   <= '0;
            update    <= 1'b0;
            done      <= 1'b0;
            dwell     <= '0;
            lat_start <= '0;
            lat_end   <= '0;
            lat_step  <= '0;
            lat_hold  <= '0;
            lat_loop  <= 1'b0;
            target    <= '0;
            dir_up    <= 1'b1;
            degen     <= 1'b0;
        end else begin
            update <= load_first | do_step;
            done   <= finish;
            if (load_cfg) begin
                lat_start <= cmp_start;
                lat_end   <= cmp_end;
                lat_step  <= cmp_step;
                lat_hold  <= hold_periods;
                lat_loop  <= loop_en;
                target    <= cmp_end;
                dir_up    <= (cmp_end >= cmp_start);
                degen     <= (cmp_start == cmp_end) || (cmp_step == '0);
            end
            if (load_first) begin
                cmp_out <= lat_start;
                dwell   <= '0;
            end
            if (dwell_inc)
                dwell <= dwell + 1'b1;
            if (do_step) begin
                cmp_out <= step_val;
                dwell   <= '0;
            end
            // Triangle turn-around: head back toward the opposite latched endpoint
            if (flip) begin
                target <= (target == lat_end) ? lat_start : lat_end;
                dir_up <= ~dir_up;
            end
        end
    end

    assign busy = (state == ARM) || (state == HOLD);

endmodule

// File: tb/tb_ef_pwm32_ramp_seq.sv
// Bench for the ramp sequencer: directed and random steps against a value-list model.
module tb_ef_pwm32_ramp_seq;

    logic        clk;
    logic        rst;
    logic        start, abort, loop_en, period_end;
    logic [31:0] cmp_start, cmp_end, cmp_step;
    logic [15:0] hold_periods;
    logic [31:0] cmp_out;
    logic        update, busy, done;

    int checks = 0;
    int errors = 0;

    ef_pwm32_ramp_seq #(.W(32), .HW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .loop_en      (loop_en),
        .period_end   (period_end),
        .cmp_start    (cmp_start),
        .cmp_end      (cmp_end),
        .cmp_step     (cmp_step),
        .hold_periods (hold_periods),
        .cmp_out      (cmp_out),
        .update       (update),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the ramp is the list of values it visits; time is counted in periods.
    longint up_vals[$];
    longint loop_tail[$];
    int     m_mode = 0;      // 0 idle, 1 waiting for first period, 2 running
    longint m_k;
    longint m_hold;
    bit     m_loop, m_single;
    longint exp_cmp = 0;
    bit     exp_upd = 0, exp_done = 0, exp_busy = 0;

    function automatic longint toward(longint v, longint st, longint tgt, bit up);
        if (up) return (v + st > tgt) ? tgt : v + st;
        return (v - st < tgt) ? tgt : v - st;
    endfunction

    task automatic build_lists(longint s, longint e, longint st);
        longint v;
        up_vals.delete();
        loop_tail.delete();
        up_vals.push_back(s);
        if (st == 0 || s == e) return;
        v = s;
        while (v != e) begin
            v = toward(v, st, e, e >= s);
            up_vals.push_back(v);
        end
        v = e;
        while (v != s) begin
            v = toward(v, st, s, s >= e);
            loop_tail.push_back(v);
        end
        for (int i = 1; i < up_vals.size(); i++)
            loop_tail.push_back(up_vals[i]);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        longint idx, n;
        exp_upd  = 0;
        exp_done = 0;
        if (abort) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    build_lists(longint'(cmp_start), longint'(cmp_end), longint'(cmp_step));
                    m_hold   = longint'(hold_periods);
                    m_loop   = loop_en;
                    m_single = (up_vals.size() == 1);
                    m_mode   = 1;
                end
                1: if (period_end) begin
                    exp_cmp = up_vals[0];
                    exp_upd = 1;
                    m_k     = 0;
                    if (m_single && !m_loop) begin
                        exp_done = 1;
                        m_mode   = 0;
                    end else begin
                        m_mode = 2;
                    end
                end
                default: if (period_end && !m_single) begin
                    m_k++;
                    if (m_k % (m_hold + 1) == 0) begin
                        idx = m_k / (m_hold + 1);
                        n   = up_vals.size() - 1;
                        if (idx <= n) exp_cmp = up_vals[idx];
                        else          exp_cmp = loop_tail[(idx - n - 1) % loop_tail.size()];
                        exp_upd = 1;
                        if (!m_loop && idx == n) begin
                            exp_done = 1;
                            m_mode   = 0;
                        end
                    end
                end
            endcase
        end
        exp_busy = (m_mode != 0);
        @(posedge clk);
        #1;
        check("cmp_out", cmp_out, exp_cmp);
        check("update", update, exp_upd);
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        start      = 0;
        abort      = 0;
        period_end = 0;
    endtask

    task automatic pe(input int n);
        for (int i = 0; i < n; i++) begin
            period_end = 1;
            tick();
            tick();
        end
    endtask

    // Issue start, then scramble the live inputs to prove they were latched
    task automatic go(input longint s, input longint e, input longint st, input int h, input bit l);
        cmp_start    = s[31:0];
        cmp_end      = e[31:0];
        cmp_step     = st[31:0];
        hold_periods = h[15:0];
        loop_en      = l;
        start        = 1;
        tick();
        cmp_start    = $urandom_range(0, 30);
        cmp_end      = $urandom_range(0, 30);
        cmp_step     = $urandom_range(0, 7);
        hold_periods = 16'($urandom_range(0, 2));
        loop_en      = $urandom_range(0, 1) != 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; loop_en = 0; period_end = 0;
        cmp_start = 0; cmp_end = 0; cmp_step = 0; hold_periods = 0;
        #12;
        check("rst cmp_out", cmp_out, 0);
        check("rst busy", busy, 0);
        check("rst update", update, 0);
        check("rst done", done, 0);
        @(posedge clk); #1;
        rst = 0;
        tick();

        go(2, 8, 3, 0, 0);   pe(4);
        go(2, 8, 4, 0, 0);   pe(3);
        go(10, 1, 4, 0, 0);  pe(4);
        go(0, 4, 2, 2, 0);   pe(9);

        go(1, 3, 1, 0, 1);   pe(8);
        check("loop at 2", cmp_out, 2);
        abort = 1; tick();
        pe(2);

        go(5, 9, 0, 0, 0);   pe(1);
        go(7, 7, 3, 0, 0);   pe(1);
        go(4, 9, 0, 1, 1);   pe(3);
        abort = 1; tick();

        go(0, 20, 1, 0, 0);  pe(1);
        cmp_start = 99; cmp_end = 100; start = 1; tick();
        pe(2);
        abort = 1; period_end = 1; tick();
        pe(1);

        go(64'hFFFF_FFF0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0); pe(2);
        go(64'hFFFF_FFFF, 3, 64'hFFFF_FFFF, 0, 0);             pe(2);
        go(64'hFFFF_FFFF, 3, 64'hFFFF_FFFF, 0, 1);             pe(4);
        abort = 1; tick();

        go(0, 50, 5, 1, 0);  pe(3);
        #2 rst = 1;
        #1;
        check("async cmp_out", cmp_out, 0);
        check("async busy", busy, 0);
        m_mode = 0; exp_cmp = 0;
        @(posedge clk); #1;
        rst = 0;
        tick();
        go(3, 6, 2, 0, 0);   pe(3);

        for (int it = 0; it < 25; it++) begin
            go($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 7),
               $urandom_range(0, 2), $urandom_range(0, 1) != 0);
            for (int j = 0; j < 40; j++) begin
                int r;
                r          = $urandom_range(0, 19);
                abort      = (r == 0);
                start      = (r == 1);
                period_end = $urandom_range(0, 1) != 0;
                tick();
            end
            abort = 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
